// File: rtl/bus_timer_resp.sv
// Memory-mapped prescaled 32-bit timer with compare match, overflow flags and irq.
// Bus responder: combinational decode/read, single-cycle full-word writes.
module bus_timer_resp #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int unsigned PSC_W     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        busWe,
   input  logic [31:0] busAddr,
   input  logic [31:0] busWData,
   output logic [31:0] busRData,
   output logic        hit,
   output logic        irq
);

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_PRESC  = 3'd1;
   localparam logic [2:0] OFF_CMP    = 3'd2;
   localparam logic [2:0] OFF_CNT    = 3'd3;
   localparam logic [2:0] OFF_STATUS = 3'd4;

   logic [2:0]       ctrl_q,  ctrl_d;
   logic [PSC_W-1:0] presc_q, presc_d;
   logic [31:0]      cmp_q,   cmp_d;
   logic [31:0]      cnt_q,   cnt_d;
   logic             match_q, match_d;
   logic             ovf_q,   ovf_d;
   logic [PSC_W-1:0] psc_q,   psc_d;
   logic             irq_q,   irq_d;

   logic [2:0] off;
   logic       wr;
   logic       wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_status;
   logic       en, tick, cnt_eq_cmp, cnt_max;
   logic       set_match, set_ovf;
   logic       clr_match, clr_ovf;
   logic       unused_addr;

   assign unused_addr = ^busAddr[1:0];

   assign hit = (busAddr[31:5] == BASE_ADDR[31:5]);
   assign off = busAddr[4:2];
   assign wr  = busWe & hit;

   assign wr_ctrl   = wr & (off == OFF_CTRL);
   assign wr_presc  = wr & (off == OFF_PRESC);
   assign wr_cmp    = wr & (off == OFF_CMP);
   assign wr_cnt    = wr & (off == OFF_CNT);
   assign wr_status = wr & (off == OFF_STATUS);

   assign en         = ctrl_q[0];
   assign tick       = en & (psc_q == presc_q);
   assign cnt_eq_cmp = (cnt_q == cmp_q);
   assign cnt_max    = (cnt_q == 32'hFFFF_FFFF);

   assign set_match = tick & cnt_eq_cmp;
   assign set_ovf   = tick & ~cnt_eq_cmp & cnt_max;
   assign clr_match = wr_status & busWData[0];
   assign clr_ovf   = wr_status & busWData[1];

   always_comb begin
      ctrl_d  = ctrl_q;
      presc_d = presc_q;
      cmp_d   = cmp_q;
      psc_d   = psc_q;
      cnt_d   = cnt_q;

      if (wr_ctrl)  ctrl_d  = busWData[2:0];
      if (wr_presc) presc_d = busWData[PSC_W-1:0];
      if (wr_cmp)   cmp_d   = busWData;

      // psc restarts on a PRESC write so the new divider takes effect cleanly
      if (wr_presc || !en || tick) psc_d = '0;
      else                         psc_d = psc_q + PSC_W'(1);

      if (tick) begin
         if (cnt_eq_cmp)   cnt_d = ctrl_q[1] ? 32'd0 : cnt_q + 32'd1;
         else if (cnt_max) cnt_d = 32'd0;
         else              cnt_d = cnt_q + 32'd1;
      end
      if (wr_cnt) cnt_d = busWData;

      // hardware set beats a same-edge write-1-to-clear
      match_d = set_match | (match_q & ~clr_match);
      ovf_d   = set_ovf   | (ovf_q   & ~clr_ovf);

      irq_d = ctrl_q[2] & (match_q | ovf_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q  <= '0;
         presc_q <= '0;
         cmp_q   <= '0;
         cnt_q   <= '0;
         match_q <= 1'b0;
         ovf_q   <= 1'b0;
         psc_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         presc_q <= presc_d;
         cmp_q   <= cmp_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
         ovf_q   <= ovf_d;
         psc_q   <= psc_d;
         irq_q   <= irq_d;
      end
   end

   assign irq = irq_q;

   always_comb begin
      busRData = 32'd0;
      if (hit) begin
         case (off)
            OFF_CTRL:   busRData = {29'd0, ctrl_q};
            OFF_PRESC:  busRData = 32'(presc_q);
            OFF_CMP:    busRData = cmp_q;
            OFF_CNT:    busRData = cnt_q;
            OFF_STATUS: busRData = {30'd0, ovf_q, match_q};
            default:    busRData = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_timer_resp.sv
// Directed bench for bus_timer_resp: register table plus timing sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_bus_timer_resp;

   localparam logic [31:0] B = 32'h0000_1000;

   logic        clk;
   logic        reset;
   logic        busWe;
   logic [31:0] busAddr;
   logic [31:0] busWData;
   logic [31:0] busRData;
   logic        hit;
   logic        irq;

   int n_pass;
   int n_total;

   bus_timer_resp #(.BASE_ADDR(B), .PSC_W(16)) dut (
      .clk(clk),
      .reset(reset),
      .busWe(busWe),
      .busAddr(busAddr),
      .busWData(busWData),
      .busRData(busRData),
      .hit(hit),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] exp_rdata;
      logic        exp_hit;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      busWe    = 1'b1;
      busAddr  = a;
      busWData = d;
      @(negedge clk);
      busWe    = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      busAddr = a;
      #1;
      d = busRData;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      @(negedge clk);
   endtask

   vec_t vt[12];
   logic [31:0] r;
   int exp_cnt3[12];

   initial begin
      reset    = 1'b0;
      busWe    = 1'b0;
      busAddr  = B;
      busWData = 32'd0;
      n_pass   = 0;
      n_total  = 0;

      vt[0]  = '{1'b1, B+32'h00, 32'hFFFF_FFF8, B+32'h00, 32'h0000_0000, 1'b1};
      vt[1]  = '{1'b1, B+32'h00, 32'hFFFF_FFFE, B+32'h00, 32'h0000_0006, 1'b1};
      vt[2]  = '{1'b1, B+32'h04, 32'hABCD_1234, B+32'h04, 32'h0000_1234, 1'b1};
      vt[3]  = '{1'b1, B+32'h08, 32'hDEAD_BEEF, B+32'h08, 32'hDEAD_BEEF, 1'b1};
      vt[4]  = '{1'b1, B+32'h0C, 32'h1234_5678, B+32'h0D, 32'h1234_5678, 1'b1};
      vt[5]  = '{1'b1, B+32'h10, 32'h0000_0000, B+32'h10, 32'h0000_0000, 1'b1};
      vt[6]  = '{1'b1, B+32'h14, 32'hFFFF_FFFF, B+32'h14, 32'h0000_0000, 1'b1};
      vt[7]  = '{1'b1, B+32'h1C, 32'hFFFF_FFFF, B+32'h1C, 32'h0000_0000, 1'b1};
      vt[8]  = '{1'b1, 32'h0000_2008, 32'h1, B+32'h08, 32'hDEAD_BEEF, 1'b1};
      vt[9]  = '{1'b0, 32'h0, 32'h0, B+32'h20, 32'h0000_0000, 1'b0};
      vt[10] = '{1'b0, 32'h0, 32'h0, 32'h1000_1000, 32'h0000_0000, 1'b0};
      vt[11] = '{1'b1, B+32'h0B, 32'h0000_0055, B+32'h08, 32'h0000_0055, 1'b1};

      exp_cnt3 = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};

      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         rd(B + 32'(i * 4), r);
         chk($sformatf("rst_reg%0d", i), r, 32'd0);
      end
      chk("rst_irq", {31'd0, irq}, 32'd0);

      for (int i = 0; i < 12; i++) begin
         if (vt[i].we) wr(vt[i].addr, vt[i].wdata);
         rd(vt[i].raddr, r);
         chk($sformatf("tbl%0d_hit", i), {31'd0, hit}, {31'd0, vt[i].exp_hit});
         chk($sformatf("tbl%0d_rd", i), r, vt[i].exp_rdata);
      end

      // reset mid-count
      do_reset();
      wr(B + 32'h08, 32'd2);
      wr(B + 32'h00, 32'd7);
      repeat (10) @(negedge clk);
      rd(B + 32'h0C, r);
      chk("t1_cnt", r, 32'd1);
      chk("t1_irq_pre", {31'd0, irq}, 32'd1);
      reset = 1'b0;
      #1;
      chk("t1_irq", {31'd0, irq}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         rd(B + 32'(i * 4), r);
         chk($sformatf("t1_reg%0d", i), r, 32'd0);
      end
      rd(B + 32'h18, r);
      chk("t1_rsv_hit", {31'd0, hit}, 32'd1);
      chk("t1_rsv_rd", r, 32'd0);
      rd(B + 32'h20, r);
      chk("t1_out_hit", {31'd0, hit}, 32'd0);
      chk("t1_out_rd", r, 32'd0);
      #1;
      reset = 1'b1;
      @(negedge clk);
      repeat (3) @(negedge clk);
      rd(B + 32'h0C, r);
      chk("t1_idle_cnt", r, 32'd0);

      // prescale by 4
      do_reset();
      wr(B + 32'h04, 32'd3);
      wr(B + 32'h08, 32'hFFFF_FFFF);
      wr(B + 32'h00, 32'd1);
      repeat (39) @(negedge clk);
      rd(B + 32'h0C, r);
      chk("t2_cnt39", r, 32'd9);
      @(negedge clk);
      rd(B + 32'h0C, r);
      chk("t2_cnt40", r, 32'd10);

      // auto-reload
      do_reset();
      wr(B + 32'h08, 32'd4);
      wr(B + 32'h00, 32'd7);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rd(B + 32'h0C, r);
         chk($sformatf("t3_cnt%0d", i + 1), r, 32'(exp_cnt3[i]));
         rd(B + 32'h10, r);
         chk($sformatf("t3_match%0d", i + 1), r, (i >= 4) ? 32'd1 : 32'd0);
         if (i == 3) chk("t3_irq_lo", {31'd0, irq}, 32'd0);
         if (i == 5) chk("t3_irq_hi", {31'd0, irq}, 32'd1);
      end
      wr(B + 32'h00, 32'd6);
      wr(B + 32'h10, 32'd1);
      rd(B + 32'h10, r);
      chk("t3_w1c", r, 32'd0);
      rd(B + 32'h0C, r);
      chk("t3_hold", r, 32'd3);
      repeat (2) @(negedge clk);
      chk("t3_irq_clr", {31'd0, irq}, 32'd0);

      // overflow
      do_reset();
      wr(B + 32'h0C, 32'hFFFF_FFFE);
      wr(B + 32'h00, 32'd1);
      @(negedge clk);
      rd(B + 32'h0C, r);
      chk("t4_cnt1", r, 32'hFFFF_FFFF);
      rd(B + 32'h10, r);
      chk("t4_st1", r, 32'd0);
      @(negedge clk);
      rd(B + 32'h0C, r);
      chk("t4_cnt2", r, 32'd0);
      rd(B + 32'h10, r);
      chk("t4_st2", r, 32'd2);
      @(negedge clk);
      rd(B + 32'h10, r);
      chk("t4_st3", r, 32'd3);
      repeat (2) @(negedge clk);
      chk("t4_irq", {31'd0, irq}, 32'd0);

      // CNT write beats tick
      do_reset();
      wr(B + 32'h08, 32'hFFFF_FFFF);
      wr(B + 32'h00, 32'd1);
      wr(B + 32'h0C, 32'h100);
      rd(B + 32'h0C, r);
      chk("t5_cnt_wr", r, 32'h100);
      @(negedge clk);
      rd(B + 32'h0C, r);
      chk("t5_cnt_nxt", r, 32'h101);

      // match set beats W1C
      do_reset();
      wr(B + 32'h08, 32'd3);
      wr(B + 32'h00, 32'd1);
      repeat (3) @(negedge clk);
      wr(B + 32'h10, 32'd1);
      rd(B + 32'h10, r);
      chk("t5_set_wins", r, 32'd1);
      rd(B + 32'h0C, r);
      chk("t5_cnt4", r, 32'd4);
      wr(B + 32'h10, 32'd1);
      rd(B + 32'h10, r);
      chk("t5_w1c", r, 32'd0);

      // PRESC rewrite mid-period
      do_reset();
      wr(B + 32'h04, 32'd7);
      wr(B + 32'h08, 32'hFFFF_FFFF);
      wr(B + 32'h00, 32'd1);
      repeat (3) @(negedge clk);
      wr(B + 32'h04, 32'd1);
      @(negedge clk);
      rd(B + 32'h0C, r);
      chk("t6_cnt_e5", r, 32'd0);
      @(negedge clk);
      rd(B + 32'h0C, r);
      chk("t6_cnt_e6", r, 32'd1);
      repeat (2) @(negedge clk);
      rd(B + 32'h0C, r);
      chk("t6_cnt_e8", r, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
